octet_stream_tx: RTL and testbench
==================================

Name: octet_stream_tx

Overview:
- Downstream stage of the RSA integer-to-octet-string converter: takes the WIDTH-bit octet string it produces and streams it out one byte per handshake, most significant octet first.
- Feeds the byte-oriented transport/record layer of the secure link.
- Supports a per-transfer octet count k, so only the least significant k octets are sent (PKCS#1 k-octet encoding); leading octets are dropped.

Parameters:
- WIDTH, 2048, bit width of the input octet string; must be a multiple of 8.
- LEN_W, $clog2(WIDTH/8)+1, width of the octet-count input (9 at default).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream octet string and in_len are valid; connects to the converter's valid output.
- in_ready  output  1  high only in IDLE; a transfer is accepted on in_valid && in_ready.
- in_data  input  WIDTH  octet string; octet 0 (MS) is in_data[WIDTH-1:WIDTH-8].
- in_len  input  LEN_W  number of octets to send, k. Values 0 and >WIDTH/8 are treated as WIDTH/8.
- out_data  output  8  current byte.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts the byte on out_valid && out_ready.
- out_last  output  1  qualifies the final byte of the transfer.
- done  output  1  one-cycle pulse on the cycle after the final byte handshake.

Behaviour:
- Reset (synchronous, priority over all else): state=IDLE; in_ready=1; out_valid=0; out_last=0; done=0; out_data=0; shift register and counters=0. Reset mid-transfer abandons the transfer; no done pulse.
- States: IDLE, SEND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_data pre-shifted left by 8*(WIDTH/8 - k), so the first octet to send sits in the top byte; load remaining count = k; go to SEND.
  - in_valid while not in IDLE is ignored.
- SEND:
  - out_valid=1; out_data = shift_reg[WIDTH-1:WIDTH-8].
  - First byte is presented the cycle after acceptance (latency 1).
  - On handshake: shift left 8, decrement count.
  - out_last=1 when count==1.
  - Handshake with count==1: go to DONE.
  - When out_ready=0: out_data, out_valid and out_last hold stable.
- DONE: done=1 for exactly one cycle; out_valid=0; then IDLE (in_ready=1 the following cycle).
- Throughput: with out_ready held high, one byte per cycle. A k-octet transfer occupies k+2 cycles from acceptance to in_ready returning high.
- k=1: single byte, with out_last asserted on it.
- Leading zero octets inside the k window are sent, not suppressed.

Optional Feature:
- Macro OCTET_STREAM_TX_CHECKSUM_EN.
- When defined: after the k data bytes, one extra byte is sent holding the XOR of all k data bytes. out_last moves to the checksum byte; data bytes never assert out_last. Transfer length becomes k+1 bytes.
- When undefined: no checksum logic; exactly k bytes, with out_last on byte k.

Test Plan:
- Reset, then in_data=0x04030201, k=4, out_ready=1 → bytes 04,03,02,01 on 4 consecutive cycles starting 1 cycle after acceptance. out_last on 01; done one cycle later. With CHECKSUM_EN: a fifth byte 04, which carries out_last.
- Same data, k=2 → bytes 02,01 only, out_last on 01.
- k=4, out_ready toggled 1,0,0,1,… → each byte held stable while stalled; sequence unchanged; no duplicated or dropped bytes.
- k=0 with in_data having 0xAB in the top octet and 0xCD in the bottom octet → 256 bytes; first is AB, last is CD with out_last.
- Pulse in_valid with 0xFF..FF during SEND → ignored; in_ready stays 0; the original stream completes intact.
- Assert reset while byte 2 of 4 is presented → out_valid=0 and in_ready=1 after the next edge, no done pulse; a new transfer is then accepted normally.

Source files
------------

// File: rtl/octet_stream_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : octet_stream_tx_if
// Description : Upstream octet-string and downstream byte-stream handshake
//               bundle for octet_stream_tx.
// Revision    : 1.0 - initial release
// ============================================================================
interface octet_stream_tx_if #(
    parameter int WIDTH = 2048,
    parameter int LEN_W = $clog2(WIDTH/8) + 1
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [LEN_W-1:0] in_len;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             done;

    // Upstream converter / downstream consumer side
    modport master (
        output in_valid, in_data, in_len, out_ready,
        input  in_ready, out_data, out_valid, out_last, done
    );

    // Streamer side
    modport slave (
        input  in_valid, in_data, in_len, out_ready,
        output in_ready, out_data, out_valid, out_last, done
    );
endinterface
`default_nettype wire

// File: rtl/octet_stream_tx.sv
`default_nettype none
// ============================================================================
// Module      : octet_stream_tx
// Description : Streams the least significant k octets of a WIDTH-bit octet
//               string, MS octet first, one byte per handshake. Optional
//               trailing XOR checksum byte via OCTET_STREAM_TX_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module octet_stream_tx #(
    parameter int WIDTH = 2048,
    parameter int LEN_W = $clog2(WIDTH/8) + 1
) (
    input  logic              clk,
    input  logic              reset,
    octet_stream_tx_if.slave  bus
);
    localparam int               c_NBYTES   = WIDTH / 8;
    localparam logic [LEN_W-1:0] c_NBYTES_L = LEN_W'(c_NBYTES);
    localparam logic [LEN_W-1:0] c_ONE      = LEN_W'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_SEND = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [LEN_W-1:0] r_count;

    logic [LEN_W-1:0] w_k;
    logic [LEN_W+2:0] w_shamt;
    logic [WIDTH-1:0] w_preload;
    logic [LEN_W-1:0] w_count_load;
    logic [7:0]       w_top;
    logic [7:0]       w_byte;
    logic             w_accept;
    logic             w_hs;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_out_last;
    logic             w_done;
    logic [7:0]       w_out_data;

    // Out-of-range counts fall back to the full string length
    assign w_k = ((bus.in_len == '0) || (bus.in_len > c_NBYTES_L)) ? c_NBYTES_L : bus.in_len;
    assign w_shamt   = {(c_NBYTES_L - w_k), 3'b000};
    assign w_preload = bus.in_data << w_shamt;
    assign w_top     = r_shift[WIDTH-1 -: 8];
    assign w_accept  = (r_state == c_IDLE) && bus.in_valid;
    assign w_hs      = (r_state == c_SEND) && bus.out_ready;

`ifdef OCTET_STREAM_TX_CHECKSUM_EN
    logic [7:0] r_csum;

    // The count covers the extra checksum byte, which goes out when it reaches one
    assign w_count_load = w_k + c_ONE;
    assign w_byte       = (r_count == c_ONE) ? r_csum : w_top;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_csum <= 8'h00;
        end else if (w_accept) begin
            r_csum <= 8'h00;
        end else if (w_hs) begin
            r_csum <= r_csum ^ w_top;
        end
    end
`else
    assign w_count_load = w_k;
    assign w_byte       = w_top;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_shift <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_shift <= w_preload;
                r_count <= w_count_load;
            end else if (w_hs) begin
                r_shift <= r_shift << 8;
                r_count <= r_count - c_ONE;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_out_last  = 1'b0;
        w_done      = 1'b0;
        w_out_data  = 8'h00;
        case (r_state)
            c_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = c_SEND;
                end
            end
            c_SEND: begin
                w_out_valid = 1'b1;
                w_out_data  = w_byte;
                w_out_last  = (r_count == c_ONE);
                if (bus.out_ready && (r_count == c_ONE)) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_last  = w_out_last;
    assign bus.out_data  = w_out_data;
    assign bus.done      = w_done;

endmodule
`default_nettype wire

// File: tb/tb_octet_stream_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_octet_stream_tx
// Description : Self-checking bench for octet_stream_tx with a queue-based
//               reference of the expected byte stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_octet_stream_tx;
    localparam int W  = 2048;
    localparam int LW = $clog2(W/8) + 1;
    localparam int NB = W / 8;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    octet_stream_tx_if #(.WIDTH(W), .LEN_W(LW)) bus ();

    octet_stream_tx #(.WIDTH(W), .LEN_W(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // stall: 0 = always ready, 1 = ready pattern 1,0,0 repeating, 2 = random
    task automatic run_xfer(input logic [W-1:0] d, input int len, input int stall, input bit inject);
        logic [7:0] q[$];
        logic [7:0] x;
        int         k;
        int         idx;
        int         cyc;
        bit         rdy;
        k = (len == 0 || len > NB) ? NB : len;
        x = 8'h00;
        for (int i = 0; i < k; i++) begin
            q.push_back(d[8*(k-1-i) +: 8]);
            x = x ^ d[8*(k-1-i) +: 8];
        end
`ifdef OCTET_STREAM_TX_CHECKSUM_EN
        q.push_back(x);
`endif
        chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_len   = LW'(len);
        @(negedge clk);
        bus.in_valid = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < q.size() && cyc < 4*NB + 16) begin
            chk("out_valid", 32'(bus.out_valid), 32'd1);
            chk("out_data", 32'(bus.out_data), 32'(q[idx]));
            chk("out_last", 32'(bus.out_last), 32'(idx == q.size() - 1));
            chk("busy_in_ready", 32'(bus.in_ready), 32'd0);
            chk("no_early_done", 32'(bus.done), 32'd0);
            case (stall)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            if (inject && cyc == 1) begin
                bus.in_valid = 1'b1;
                bus.in_data  = '1;
                bus.in_len   = '0;
            end else begin
                bus.in_valid = 1'b0;
            end
            bus.out_ready = rdy;
            @(negedge clk);
            if (rdy) idx++;
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("stream_complete", 32'(idx), 32'(q.size()));
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("done_out_valid", 32'(bus.out_valid), 32'd0);
        chk("done_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        chk("ret_in_ready", 32'(bus.in_ready), 32'd1);
        chk("done_one_cycle", 32'(bus.done), 32'd0);
    endtask

    initial begin
        logic [W-1:0] d;
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_len    = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_last", 32'(bus.out_last), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        d = '0;
        d[31:0] = 32'h04030201;
        run_xfer(d, 4, 0, 1'b0);
        run_xfer(d, 2, 0, 1'b0);
        run_xfer(d, 4, 1, 1'b0);
        run_xfer(d, 1, 0, 1'b0);
        run_xfer(d, 4, 1, 1'b1);

        d = '0;
        d[W-1 -: 8] = 8'hAB;
        d[7:0]      = 8'hCD;
        run_xfer(d, 0, 0, 1'b0);
        run_xfer(d, 300, 0, 1'b0);

        // Reset while the second of four bytes is on the bus
        d = '0;
        d[31:0] = 32'h04030201;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_len   = LW'(4);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_byte2", 32'(bus.out_data), 32'h03);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_done", 32'(bus.done), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("postrst_done", 32'(bus.done), 32'd0);
        run_xfer(d, 4, 0, 1'b0);

        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < W/32; i++) d[32*i +: 32] = $urandom;
            run_xfer(d, int'($urandom_range(0, 300)), 2, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
